signal_tracker_query_sequencer: RTL and testbench
=================================================

Name: signal_tracker_query_sequencer

Overview:
- Consumer and driver of the time-test signal tracker.
- Queues timestamped trace events, converts each timestamp into a cycles-back look-up, and runs the recalculate_time / data_valid handshake against the tracker.
- Captures the returned [start, end] pair and emits one tagged record per event to the downstream trace packer over a valid/ready interface.

Parameters:
- FIFO_DEPTH, 4, event queue depth; power of 2, at least 2.
- BUFFER_WIDTH, 8, history depth of the attached tracker; look-ups deeper than this are rejected locally.
- TAG_WIDTH, 8, width of the opaque event tag carried through to the record.
- TIMEOUT_CYCLES, 16, maximum REQ-state wait for data_valid before abandoning the query.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- counter  in  32  free-running cycle counter shared with the tracker
- event_valid  in  1  event offered
- event_ready  out  1  queue can accept an event
- event_time  in  32  counter value at which the event occurred
- event_tag  in  TAG_WIDTH  event identifier
- recalculate_time  out  1  look-up request to the tracker
- value_in  out  32  cycles back to search
- data_valid  in  1  tracker result valid
- time_out_start  in  32  tracker result start time (all-ones = none)
- time_out_end  in  32  tracker result end time (all-ones = none)
- rec_valid  out  1  record valid
- rec_ready  in  1  record accepted
- rec_tag  out  TAG_WIDTH  tag of the originating event
- rec_start  out  32  interval start
- rec_end  out  32  interval end
- rec_status  out  2  00 ok, 01 not found, 10 out of window, 11 timeout

Behaviour:
- Reset (async assert, sync release): all outputs 0; event_ready rises on the first clock after release; FIFO empty; state IDLE; timeout counter 0.
- Reset mid-handshake: recalculate_time drops immediately; any in-flight record is discarded.
- FIFO:
  - event_ready = !full.
  - Push on event_valid && event_ready.
  - Push and pop in the same cycle are allowed at any occupancy.
  - Pointers are log2(FIFO_DEPTH)+1 bits so full/empty is distinguished on wrap.
- FSM states: IDLE, CHECK, REQ, RELEASE, EMIT.
- IDLE: if FIFO non-empty, pop the head into holding registers and go to CHECK. Pop latency is 1 cycle.
- CHECK: delta = counter - held_time + 1, 32-bit unsigned with wrap; the +1 covers the tracker's registered sampling.
  - delta <= 1: stay in CHECK until the event is in tracker history.
  - delta > BUFFER_WIDTH: set start = end = all-ones, status 10, go to EMIT; no request issued.
  - Otherwise: register value_in = delta, assert recalculate_time, clear the timeout counter, go to REQ.
- REQ:
  - value_in and recalculate_time are held stable.
  - On data_valid: capture time_out_start/end, deassert recalculate_time, go to RELEASE.
  - Status is 01 if captured start = all-ones, else 00. Start valid with end all-ones is still 00; the packer treats it as open-ended.
  - On timeout counter reaching TIMEOUT_CYCLES-1 without data_valid: deassert recalculate_time, set start = end = all-ones, status 11, go to EMIT.
- RELEASE:
  - Wait for data_valid = 0, then go to EMIT.
  - If data_valid is already 0 on entry, move to EMIT next cycle.
  - No new request may be issued until data_valid is seen low.
- EMIT:
  - rec_valid = 1; rec_* fields are held stable until rec_valid && rec_ready.
  - On acceptance, go to IDLE; rec_valid drops next cycle.
- Throughput: at best one record per 5 cycles. The FIFO keeps accepting while the FSM is busy.
- Record order equals event acceptance order.

Optional Feature:
- Macro: SIGNAL_TRACKER_QUERY_STATS_EN.
- When defined:
  - Adds outputs stat_queries (16), stat_misses (16) and stat_timeouts (16).
  - stat_queries: saturating count of requests issued.
  - stat_misses: count of status 01 or 10 records.
  - stat_timeouts: count of status 11 records.
  - All three clear on reset.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then push tag 0x11, time 100, with counter = 103:
  - value_in = 4 and recalculate_time held until data_valid.
  - Tracker returns {101,102}.
  - Record tag 0x11, start 101, end 102, status 00.
- Push time 50 at counter 100, BUFFER_WIDTH 8 -> no recalculate_time; record start = end = 0xFFFFFFFF, status 10.
- Tracker never asserts data_valid -> recalculate_time drops after 16 cycles in REQ; record status 11.
- Push 5 events back-to-back with rec_ready = 0:
  - event_ready low after 4 queued plus 1 held.
  - Records emerge in order once rec_ready = 1.
  - No event is lost or duplicated.
- data_valid held high 3 extra cycles after the request drops -> FSM stays in RELEASE; next recalculate_time is not asserted until data_valid = 0.
- rst_n pulsed low while in REQ -> recalculate_time and rec_valid are 0 asynchronously; FIFO empty; event_ready = 1 after release.

Source files
------------

// File: rtl/signal_tracker_query_sequencer.sv
// ---------------------------------------------------------------------------
// signal_tracker_query_sequencer
//
// Queues timestamped trace events, turns each timestamp into a cycles-back
// look-up against the time-test signal tracker, runs the
// recalculate_time / data_valid handshake and hands one tagged record per
// event to the downstream trace packer.
//
// Optional feature macro: SIGNAL_TRACKER_QUERY_STATS_EN
//   When defined, adds saturating 16-bit statistics outputs
//   stat_queries / stat_misses / stat_timeouts.
//
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   counter           free-running cycle counter shared with the tracker
//   event_valid/ready event push handshake (ready = queue not full)
//   event_time        counter value at which the event occurred
//   event_tag         opaque event identifier
//   recalculate_time  look-up request to the tracker
//   value_in          number of cycles back to search
//   data_valid        tracker result valid
//   time_out_start    tracker result start (all-ones = none)
//   time_out_end      tracker result end   (all-ones = none)
//   rec_valid/ready   record handshake towards the packer
//   rec_tag           tag of the originating event
//   rec_start/rec_end captured interval
//   rec_status        00 ok, 01 not found, 10 out of window, 11 timeout
// ---------------------------------------------------------------------------
module signal_tracker_query_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int BUFFER_WIDTH   = 8,
    parameter int TAG_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          counter,
    input  logic                 event_valid,
    output logic                 event_ready,
    input  logic [31:0]          event_time,
    input  logic [TAG_WIDTH-1:0] event_tag,
    output logic                 recalculate_time,
    output logic [31:0]          value_in,
    input  logic                 data_valid,
    input  logic [31:0]          time_out_start,
    input  logic [31:0]          time_out_end,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [TAG_WIDTH-1:0] rec_tag,
    output logic [31:0]          rec_start,
    output logic [31:0]          rec_end,
    output logic [1:0]           rec_status
`ifdef SIGNAL_TRACKER_QUERY_STATS_EN
    ,
    output logic [15:0]          stat_queries,
    output logic [15:0]          stat_misses,
    output logic [15:0]          stat_timeouts
`endif
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW  = AW + 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]    BUF_LIMIT  = 32'(BUFFER_WIDTH);
    localparam logic [31:0]    ALL_ONES   = 32'hFFFF_FFFF;

    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_MISS    = 2'b01;
    localparam logic [1:0] STS_WINDOW  = 2'b10;
    localparam logic [1:0] STS_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_EMIT    = 3'd4
    } state_e;

    // ---------------- FIFO storage and pointers ----------------
    logic [31:0]          fifo_time_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag_q  [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 event_ready_q, event_ready_d;
    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic [31:0]          head_time_s;
    logic [TAG_WIDTH-1:0] head_tag_s;

    // ---------------- sequencer state ----------------
    state_e               state_q, state_d;
    logic [31:0]          held_time_q, held_time_d;
    logic [TAG_WIDTH-1:0] held_tag_q, held_tag_d;
    logic [31:0]          value_in_q, value_in_d;
    logic                 recalc_q, recalc_d;
    logic [TCW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                 rec_valid_q, rec_valid_d;
    logic [TAG_WIDTH-1:0] rec_tag_q, rec_tag_d;
    logic [31:0]          rec_start_q, rec_start_d;
    logic [31:0]          rec_end_q, rec_end_d;
    logic [1:0]           rec_status_q, rec_status_d;
    logic [31:0]          delta_s;

    assign push_s      = event_valid && event_ready_q;
    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    assign head_time_s = fifo_time_q[rd_ptr_q[AW-1:0]];
    assign head_tag_s  = fifo_tag_q[rd_ptr_q[AW-1:0]];

    // The +1 accounts for the tracker sampling the signal one cycle late.
    assign delta_s = counter - held_time_q + 32'd1;

    // FIFO entry storage, written on every accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_time_q[i] <= 32'd0;
                fifo_tag_q[i]  <= '0;
            end
        end else if (push_s) begin
            fifo_time_q[wr_ptr_q[AW-1:0]] <= event_time;
            fifo_tag_q[wr_ptr_q[AW-1:0]]  <= event_tag;
        end
    end

    // Next pointers; ready is registered from the next-cycle occupancy so it
    // stays exact while remaining a flop output.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        event_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                          (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    // FIFO pointer and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            event_ready_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            event_ready_q <= event_ready_d;
        end
    end

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        held_time_d  = held_time_q;
        held_tag_d   = held_tag_q;
        value_in_d   = value_in_q;
        recalc_d     = recalc_q;
        tmo_cnt_d    = tmo_cnt_q;
        rec_valid_d  = rec_valid_q;
        rec_tag_d    = rec_tag_q;
        rec_start_d  = rec_start_q;
        rec_end_d    = rec_end_q;
        rec_status_d = rec_status_q;
        pop_s        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    held_time_d = head_time_s;
                    held_tag_d  = head_tag_s;
                    state_d     = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (delta_s <= 32'd1) begin
                    // Event not yet visible in tracker history; keep waiting.
                    state_d = ST_CHECK;
                end else if (delta_s > BUF_LIMIT) begin
                    rec_start_d  = ALL_ONES;
                    rec_end_d    = ALL_ONES;
                    rec_status_d = STS_WINDOW;
                    rec_tag_d    = held_tag_q;
                    rec_valid_d  = 1'b1;
                    state_d      = ST_EMIT;
                end else begin
                    value_in_d = delta_s;
                    recalc_d   = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = ST_REQ;
                end
            end

            ST_REQ: begin
                if (data_valid) begin
                    rec_start_d  = time_out_start;
                    rec_end_d    = time_out_end;
                    rec_status_d = (time_out_start == ALL_ONES) ? STS_MISS : STS_OK;
                    recalc_d     = 1'b0;
                    state_d      = ST_RELEASE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    recalc_d     = 1'b0;
                    rec_start_d  = ALL_ONES;
                    rec_end_d    = ALL_ONES;
                    rec_status_d = STS_TIMEOUT;
                    rec_tag_d    = held_tag_q;
                    rec_valid_d  = 1'b1;
                    state_d      = ST_EMIT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TCW'(1);
                    state_d   = ST_REQ;
                end
            end

            ST_RELEASE: begin
                // The tracker must drop data_valid before any new request.
                if (!data_valid) begin
                    rec_tag_d   = held_tag_q;
                    rec_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else begin
                    state_d = ST_RELEASE;
                end
            end

            ST_EMIT: begin
                if (rec_ready) begin
                    rec_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end

            default: begin
                recalc_d    = 1'b0;
                rec_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            held_time_q  <= 32'd0;
            held_tag_q   <= '0;
            value_in_q   <= 32'd0;
            recalc_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            rec_valid_q  <= 1'b0;
            rec_tag_q    <= '0;
            rec_start_q  <= 32'd0;
            rec_end_q    <= 32'd0;
            rec_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            held_time_q  <= held_time_d;
            held_tag_q   <= held_tag_d;
            value_in_q   <= value_in_d;
            recalc_q     <= recalc_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rec_valid_q  <= rec_valid_d;
            rec_tag_q    <= rec_tag_d;
            rec_start_q  <= rec_start_d;
            rec_end_q    <= rec_end_d;
            rec_status_q <= rec_status_d;
        end
    end

    assign event_ready      = event_ready_q;
    assign recalculate_time = recalc_q;
    assign value_in         = value_in_q;
    assign rec_valid        = rec_valid_q;
    assign rec_tag          = rec_tag_q;
    assign rec_start        = rec_start_q;
    assign rec_end          = rec_end_q;
    assign rec_status       = rec_status_q;

`ifdef SIGNAL_TRACKER_QUERY_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic [15:0] stat_queries_q, stat_queries_d;
    logic [15:0] stat_misses_q, stat_misses_d;
    logic [15:0] stat_timeouts_q, stat_timeouts_d;

    // Statistics: requests counted when issued, outcomes when accepted
    always_comb begin
        stat_queries_d  = stat_queries_q;
        stat_misses_d   = stat_misses_q;
        stat_timeouts_d = stat_timeouts_q;
        if ((state_q == ST_CHECK) && (state_d == ST_REQ)) begin
            stat_queries_d = sat_inc16(stat_queries_q);
        end else begin
            stat_queries_d = stat_queries_q;
        end
        if (rec_valid_q && rec_ready) begin
            case (rec_status_q)
                STS_MISS, STS_WINDOW: stat_misses_d   = sat_inc16(stat_misses_q);
                STS_TIMEOUT:          stat_timeouts_d = sat_inc16(stat_timeouts_q);
                default: begin
                    stat_misses_d   = stat_misses_q;
                    stat_timeouts_d = stat_timeouts_q;
                end
            endcase
        end else begin
            stat_misses_d   = stat_misses_q;
            stat_timeouts_d = stat_timeouts_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_queries_q  <= 16'd0;
            stat_misses_q   <= 16'd0;
            stat_timeouts_q <= 16'd0;
        end else begin
            stat_queries_q  <= stat_queries_d;
            stat_misses_q   <= stat_misses_d;
            stat_timeouts_q <= stat_timeouts_d;
        end
    end

    assign stat_queries  = stat_queries_q;
    assign stat_misses   = stat_misses_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_signal_tracker_query_sequencer.sv
// Self-checking bench for signal_tracker_query_sequencer: directed vector
// table, hand-written multi-cycle sequences and a randomized run against a
// queue-based reference model with a behavioural tracker responder.
module tb_signal_tracker_query_sequencer;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] counter;
    logic        event_valid;
    logic        event_ready;
    logic [31:0] event_time;
    logic [7:0]  event_tag;
    logic        recalculate_time;
    logic [31:0] value_in;
    logic        data_valid;
    logic [31:0] time_out_start;
    logic [31:0] time_out_end;
    logic        rec_valid;
    logic        rec_ready;
    logic [7:0]  rec_tag;
    logic [31:0] rec_start;
    logic [31:0] rec_end;
    logic [1:0]  rec_status;
`ifdef SIGNAL_TRACKER_QUERY_STATS_EN
    logic [15:0] stat_queries;
    logic [15:0] stat_misses;
    logic [15:0] stat_timeouts;
`endif

    signal_tracker_query_sequencer #(
        .FIFO_DEPTH(4), .BUFFER_WIDTH(8), .TAG_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .counter(counter),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_time(event_time), .event_tag(event_tag),
        .recalculate_time(recalculate_time), .value_in(value_in),
        .data_valid(data_valid), .time_out_start(time_out_start),
        .time_out_end(time_out_end),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_tag(rec_tag),
        .rec_start(rec_start), .rec_end(rec_end), .rec_status(rec_status)
`ifdef SIGNAL_TRACKER_QUERY_STATS_EN
        , .stat_queries(stat_queries), .stat_misses(stat_misses),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ev_time;
        logic [7:0]  tag;
        logic [31:0] cnt;
        logic [31:0] rsp_start;
        logic [31:0] rsp_end;
        logic        exp_req;
        logic [31:0] exp_value;
        logic [31:0] exp_start;
        logic [31:0] exp_end;
        logic [1:0]  exp_status;
    } vec_t;

    typedef struct { logic [31:0] t; logic [7:0] tag; } ev_t;
    typedef struct { logic [31:0] value; logic [31:0] s; logic [31:0] e; bit to; } pend_t;

    vec_t  vecs[7];
    ev_t   model_q[$];
    pend_t pend_q[$];

    // Push one event, waiting (bounded) for the queue to accept it.
    task automatic push_event(input string name, input logic [31:0] t, input logic [7:0] tag);
        int g;
        event_time  = t;
        event_tag   = tag;
        event_valid = 1'b1;
        g = 0;
        while (!event_ready && g < 40) begin tick(); g++; end
        check({name, "_accept"}, event_ready, 1'b1);
        tick();
        event_valid = 1'b0;
    endtask

    // Wait (bounded) for rec_valid, compare the record, accept it.
    task automatic take_record(input string name, input logic [7:0] tag, input logic [31:0] s,
                               input logic [31:0] e, input logic [1:0] st);
        int g;
        g = 0;
        while (!rec_valid && g < 60) begin tick(); g++; end
        check({name, "_rec_valid"}, rec_valid, 1'b1);
        check({name, "_tag"}, rec_tag, tag);
        check({name, "_start"}, rec_start, s);
        check({name, "_end"}, rec_end, e);
        check({name, "_status"}, rec_status, st);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check({name, "_rec_drop"}, rec_valid, 1'b0);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        bit    req_seen;
        bit    done;
        string nm;
        nm = $sformatf("vec%0d", idx);
        counter = v.cnt;
        push_event(nm, v.ev_time, v.tag);
        req_seen = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (rec_valid) begin
                done = 1'b1;
            end else begin
                if (recalculate_time && !data_valid) begin
                    req_seen = 1'b1;
                    check({nm, "_value_in"}, value_in, v.exp_value);
                    data_valid     = 1'b1;
                    time_out_start = v.rsp_start;
                    time_out_end   = v.rsp_end;
                end else if (!recalculate_time && data_valid) begin
                    data_valid = 1'b0;
                end
                tick();
            end
        end
        data_valid = 1'b0;
        check({nm, "_request_issued"}, req_seen, v.exp_req);
        take_record(nm, v.tag, v.exp_start, v.exp_end, v.exp_status);
    endtask

    // random-run state
    bit          rsp_active;
    bit          rsp_to;
    int          rsp_wait;
    int          rsp_hold;
    int          rsp_hi;
    pend_t       rsp_p;
    int          ev_left;
    logic [7:0]  tag_next;
    ev_t         m;
    pend_t       q;
    logic [31:0] delta;
    int          g;
    bit          activity;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // expected results worked out by hand from the look-up rules
        vecs[0] = '{32'd100, 8'h11, 32'd103, 32'd101, 32'd102, 1'b1, 32'd4, 32'd101, 32'd102, 2'b00};
        vecs[1] = '{32'd50, 8'h12, 32'd100, 32'd0, 32'd0, 1'b0, 32'd0, ONES, ONES, 2'b10};
        vecs[2] = '{32'd95, 8'h13, 32'd100, ONES, ONES, 1'b1, 32'd6, ONES, ONES, 2'b01};
        vecs[3] = '{32'd92, 8'h14, 32'd99, 32'd90, ONES, 1'b1, 32'd8, 32'd90, ONES, 2'b00};
        vecs[4] = '{32'd91, 8'h15, 32'd99, 32'd0, 32'd0, 1'b0, 32'd0, ONES, ONES, 2'b10};
        vecs[5] = '{32'd99, 8'h16, 32'd100, 32'd99, 32'd100, 1'b1, 32'd2, 32'd99, 32'd100, 2'b00};
        vecs[6] = '{32'hFFFF_FFFE, 8'h17, 32'd1, 32'hFFFF_FFFD, 32'd0, 1'b1, 32'd4,
                    32'hFFFF_FFFD, 32'd0, 2'b00};

        rst_n = 1'b0; counter = 32'd0; event_valid = 1'b0; event_time = 32'd0;
        event_tag = 8'd0; data_valid = 1'b0; time_out_start = 32'd0;
        time_out_end = 32'd0; rec_ready = 1'b0;
        tick(); tick();
        check("rst_event_ready", event_ready, 1'b0);
        check("rst_recalc", recalculate_time, 1'b0);
        check("rst_value_in", value_in, 32'd0);
        check("rst_rec_valid", rec_valid, 1'b0);
        check("rst_rec_fields", {rec_tag, rec_start, rec_end, rec_status} == '0, 1'b1);
        rst_n = 1'b1;
        check("release_ready_low", event_ready, 1'b0);
        tick();
        check("release_ready_high", event_ready, 1'b1);

        for (int i = 0; i < 7; i++) run_vector(vecs[i], i);

        // Tracker silent: request held exactly 16 cycles, then timeout record.
        counter = 32'd103;
        push_event("tmo", 32'd100, 8'h33);
        g = 0;
        while (!recalculate_time && g < 10) begin tick(); g++; end
        check("tmo_req", recalculate_time, 1'b1);
        rsp_hi = 0;
        while (recalculate_time && rsp_hi < 40) begin
            rsp_hi++;
            tick();
        end
        check("tmo_req_cycles", rsp_hi, 16);
        take_record("tmo", 8'h33, ONES, ONES, 2'b11);

        // data_valid held 3 cycles beyond the request drop keeps FSM in RELEASE.
        push_event("rel", 32'd100, 8'h44);
        g = 0;
        while (!recalculate_time && g < 10) begin tick(); g++; end
        check("rel_req", recalculate_time, 1'b1);
        data_valid = 1'b1; time_out_start = 32'd101; time_out_end = 32'd102;
        tick();
        check("rel_req_drop", recalculate_time, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rel_hold%0d_no_rec", k), rec_valid, 1'b0);
            check($sformatf("rel_hold%0d_no_req", k), recalculate_time, 1'b0);
            tick();
        end
        check("rel_still_held", rec_valid, 1'b0);
        data_valid = 1'b0;
        take_record("rel", 8'h44, 32'd101, 32'd102, 2'b00);

        // Backpressure: 4 queued + 1 held fills the block.
        counter = 32'd1000;
        for (int i = 0; i < 5; i++) begin
            event_time = 32'd10; event_tag = 8'hA0 + 8'(i); event_valid = 1'b1;
            g = 0;
            while (!event_ready && g < 10) begin tick(); g++; end
            check($sformatf("bp_push%0d", i), event_ready, 1'b1);
            tick();
        end
        event_tag = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_full%0d", k), event_ready, 1'b0);
            tick();
        end
        event_valid = 1'b0;
        for (int i = 0; i < 5; i++)
            take_record($sformatf("bp_rec%0d", i), 8'hA0 + 8'(i), ONES, ONES, 2'b10);
        activity = 1'b0;
        for (int k = 0; k < 8; k++) begin activity |= rec_valid; tick(); end
        check("bp_no_duplicate", activity, 1'b0);

        // Reset pulse while a request is outstanding and another event queued.
        counter = 32'd103;
        push_event("mid1", 32'd100, 8'h55);
        push_event("mid2", 32'd100, 8'h56);
        g = 0;
        while (!recalculate_time && g < 10) begin tick(); g++; end
        check("mid_req", recalculate_time, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_recalc", recalculate_time, 1'b0);
        check("mid_rst_rec_valid", rec_valid, 1'b0);
        check("mid_rst_ready", event_ready, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("mid_release_ready", event_ready, 1'b1);
        activity = 1'b0;
        for (int k = 0; k < 10; k++) begin activity |= recalculate_time | rec_valid; tick(); end
        check("mid_fifo_empty", activity, 1'b0);

        // Randomized run against queue model with behavioural tracker.
        counter    = 32'h0001_0000;
        ev_left    = 60;
        tag_next   = 8'd0;
        rsp_active = 1'b0;
        for (int cyc = 0; cyc < 4000 && (ev_left > 0 || model_q.size() > 0); cyc++) begin
            if (!rsp_active && recalculate_time) begin
                rsp_active  = 1'b1;
                rsp_to      = ($urandom_range(0, 5) == 0);
                rsp_wait    = $urandom_range(0, 3);
                rsp_hold    = $urandom_range(0, 3);
                rsp_hi      = 0;
                rsp_p.value = value_in;
                rsp_p.to    = rsp_to;
                rsp_p.s     = ($urandom_range(0, 3) == 0) ? ONES : 32'($urandom);
                rsp_p.e     = ($urandom_range(0, 3) == 0) ? ONES : 32'($urandom);
                pend_q.push_back(rsp_p);
            end
            if (rsp_active) begin
                if (recalculate_time) begin
                    rsp_hi++;
                    check("rnd_value_hold", value_in, rsp_p.value);
                end
                if (rsp_to) begin
                    data_valid = 1'b0;
                    if (!recalculate_time) begin
                        check("rnd_timeout_len", rsp_hi, 16);
                        rsp_active = 1'b0;
                    end
                end else if (rsp_wait > 0) begin
                    rsp_wait--;
                    data_valid = 1'b0;
                end else if (recalculate_time) begin
                    data_valid = 1'b1; time_out_start = rsp_p.s; time_out_end = rsp_p.e;
                end else if (rsp_hold > 0) begin
                    rsp_hold--;
                    data_valid = 1'b1;
                end else begin
                    data_valid = 1'b0;
                    rsp_active = 1'b0;
                end
            end
            if (ev_left > 0 && $urandom_range(0, 2) != 0) begin
                event_time  = counter - 32'($urandom_range(2, 12)) + 32'd1;
                event_tag   = tag_next;
                event_valid = 1'b1;
            end else begin
                event_valid = 1'b0;
            end
            rec_ready = ($urandom_range(0, 3) != 0);
            if (event_valid && event_ready) begin
                model_q.push_back('{event_time, event_tag});
                tag_next++;
                ev_left--;
            end
            if (rec_valid && rec_ready) begin
                if (model_q.size() == 0) begin
                    check("rnd_unexpected_record", 1'b1, 1'b0);
                end else begin
                    m = model_q.pop_front();
                    delta = counter - m.t + 32'd1;
                    check("rnd_tag", rec_tag, m.tag);
                    if (delta > 32'd8) begin
                        check("rnd_win_rec", {rec_start, rec_end, rec_status}, {ONES, ONES, 2'b10});
                    end else if (pend_q.size() == 0) begin
                        check("rnd_missing_request", 1'b0, 1'b1);
                    end else begin
                        q = pend_q.pop_front();
                        check("rnd_value_in", q.value, delta);
                        if (q.to)
                            check("rnd_tmo_rec", {rec_start, rec_end, rec_status}, {ONES, ONES, 2'b11});
                        else
                            check("rnd_rsp_rec", {rec_start, rec_end, rec_status},
                                  {q.s, q.e, (q.s == ONES) ? 2'b01 : 2'b00});
                    end
                end
            end
            tick();
        end
        event_valid = 1'b0; rec_ready = 1'b0; data_valid = 1'b0;
        check("rnd_all_pushed", ev_left, 0);
        check("rnd_drained", model_q.size(), 0);
        check("rnd_no_extra_request", pend_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
